// File: rtl/rv_mem_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and data access.
// Data wins by default; IF is granted after MAX_D_BURST back-to-back data grants while it waits.
module rv_mem_arbiter #(
  parameter int MEM_LAT     = 2,
  parameter int MAX_D_BURST = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        owner_if_q, owner_if_d;
  logic        kill_q, kill_d;
  logic [3:0]  burst_q, burst_d;
  logic [3:0]  lat_q, lat_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;

  logic gnt_d, gnt_if;

  always_comb begin
    gnt_d  = 1'b0;
    gnt_if = 1'b0;
    if (d_req && (burst_q < 4'(MAX_D_BURST))) begin
      gnt_d = 1'b1;
    end else if (if_req && !if_kill) begin
      gnt_if = 1'b1;
    end else if (d_req) begin
      gnt_d = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_if_d  = owner_if_q;
    kill_d      = kill_q;
    burst_d     = burst_q;
    lat_d       = lat_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (gnt_d) begin
          owner_if_d  = 1'b0;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_wstrb;
          // Only data grants that actually bypass a waiting fetch count toward the burst.
          if (!if_req) begin
            burst_d = 4'd0;
          end else if (burst_q < 4'(MAX_D_BURST)) begin
            burst_d = burst_q + 4'd1;
          end
          state_d = ISSUE;
        end else if (gnt_if) begin
          owner_if_d  = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wstrb_d = 4'b0000;
          burst_d     = 4'd0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = 4'(MEM_LAT - 1);
        state_d = (MEM_LAT == 1) ? RESP : WAIT;
      end
      WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) && owner_if_q && if_kill) begin
      kill_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_if_q  <= 1'b0;
      kill_q      <= 1'b0;
      burst_q     <= 4'd0;
      lat_q       <= 4'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      owner_if_q  <= owner_if_d;
      kill_q      <= kill_d;
      burst_q     <= burst_d;
      lat_q       <= lat_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en & mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign busy      = (state_q != IDLE);

  // A kill arriving in the response cycle itself must still swallow the fetch.
  assign if_ready  = (state_q == RESP) & owner_if_q & ~kill_q & ~if_kill;
  assign d_ready   = (state_q == RESP) & ~owner_if_q;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign if_stall  = if_req & ~if_ready;
  assign d_stall   = d_req & ~d_ready;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: a transaction-level timing model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_rv_mem_arbiter;
  localparam int MEM_LAT     = 2;
  localparam int MAX_D_BURST = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_kill, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, if_stall, d_ready, d_stall, mem_en, mem_we, busy;
  logic [3:0]  mem_wstrb;

  rv_mem_arbiter #(.MEM_LAT(MEM_LAT), .MAX_D_BURST(MAX_D_BURST)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory: contents are a fixed function of the address captured at issue.
  function automatic logic [31:0] memfun(input logic [31:0] a);
    return (a == 32'd0) ? 32'h00500293 : ((a ^ 32'hA5A5_0000) + 32'h11);
  endfunction

  logic [31:0] lat_addr = 32'd0;
  always @(posedge clk) if (mem_en) lat_addr <= mem_addr;
  assign mem_rdata = memfun(lat_addr);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: one outstanding access described by its grant cycle and fields.
  int          c = 0;
  bit          m_act = 0, m_if = 0, m_we = 0, m_kill = 0;
  int          m_t = 0;
  int          m_burst = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [3:0]  m_wstrb = 0;
  bit          in_win, e_en, e_resp, e_ir, e_dr;

  always @(negedge clk) begin
    c++;
    if (rst) begin
      m_act = 0;
      m_burst = 0;
      chk("rst_busy", busy, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_if_ready", if_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_wstrb", mem_wstrb, 0);
    end else begin
      in_win = m_act && (c >= m_t + 1) && (c <= m_t + 1 + MEM_LAT);
      if (in_win && m_if && if_kill) m_kill = 1;
      e_en   = m_act && (c == m_t + 1);
      e_resp = m_act && (c == m_t + 1 + MEM_LAT);
      e_ir   = e_resp && m_if && !m_kill;
      e_dr   = e_resp && !m_if;
      chk("busy", busy, in_win);
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_en && m_we);
      chk("if_ready", if_ready, e_ir);
      chk("d_ready", d_ready, e_dr);
      chk("if_stall", if_stall, if_req && !e_ir);
      chk("d_stall", d_stall, d_req && !e_dr);
      if (e_en) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wstrb", mem_wstrb, m_if ? 4'b0000 : m_wstrb);
        if (!m_if && m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (e_ir) chk("if_rdata", if_rdata, memfun(m_addr));
      if (e_dr && !m_we) chk("d_rdata", d_rdata, memfun(m_addr));
      if (!in_win) begin
        if (d_req && (m_burst < MAX_D_BURST || !(if_req && !if_kill))) begin
          m_act = 1; m_t = c; m_if = 0; m_kill = 0;
          m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_wstrb = d_wstrb;
          m_burst = if_req ? ((m_burst + 1 > MAX_D_BURST) ? MAX_D_BURST : m_burst + 1) : 0;
        end else if (if_req && !if_kill) begin
          m_act = 1; m_t = c; m_if = 1; m_kill = 0;
          m_we = 0; m_addr = if_addr;
          m_burst = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit want_if, input int bound, output int n);
    bit ok;
    n = 0;
    ok = 0;
    while (n < bound && !ok) begin
      @(negedge clk);
      n++;
      ok = want_if ? (if_ready === 1'b1) : (d_ready === 1'b1);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout got=none exp=%s_ready within %0d", want_if ? "if" : "d", bound);
    end
    step();
  endtask

  task automatic wait_any(input int bound, output bit got_if);
    bit ok;
    int n;
    n = 0;
    ok = 0;
    got_if = 0;
    while (n < bound && !ok) begin
      @(negedge clk);
      n++;
      if (if_ready === 1'b1 || d_ready === 1'b1) begin
        ok = 1;
        got_if = (if_ready === 1'b1);
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL any_ready_timeout got=none exp=a_ready within %0d", bound);
    end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n;
    bit    gi;
    string ord;
    rst = 1; if_req = 0; if_addr = 0; if_kill = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // single fetch from address 0
    if_req = 1; if_addr = 32'h0;
    @(negedge clk);
    @(negedge clk); chk("t1_en", mem_en, 1); chk("t1_addr", mem_addr, 32'h0);
    @(negedge clk);
    @(negedge clk); chk("t1_ir", if_ready, 1); chk("t1_rdata", if_rdata, 32'h00500293);
    step(); if_req = 0;
    @(negedge clk); chk("t1_busy", busy, 0);

    // simultaneous fetch and load: data first
    step();
    if_req = 1; if_addr = 32'h4; d_req = 1; d_we = 0; d_addr = 32'h100;
    wait_ready(0, 20, n); chk("t2_dlat", n, 4); d_req = 0;
    wait_ready(1, 20, n); chk("t2_ilat", n, 4); if_req = 0;

    // starvation guard
    d_req = 1; d_addr = 32'h200; if_req = 1; if_addr = 32'h8;
    ord = "";
    for (int i = 0; i < 6; i++) begin
      wait_any(20, gi);
      if (gi) begin ord = {ord, "I"}; if_addr = if_addr + 4; end
      else begin ord = {ord, "D"}; d_addr = d_addr + 4; end
    end
    d_req = 0; if_req = 0;
    checks++;
    if (ord != "DDIDDI") begin
      failures++;
      $display("FAIL t3_order got=%s exp=DDIDDI", ord);
    end

    // store
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
    @(negedge clk);
    @(negedge clk);
    chk("t4_en", mem_en, 1); chk("t4_we", mem_we, 1);
    chk("t4_wstrb", mem_wstrb, 4'b0011); chk("t4_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    wait_ready(0, 20, n); chk("t4_dlat", n, 2);
    d_req = 0; d_we = 0; d_wstrb = 0;

    // kill during WAIT, data pending
    if_req = 1; if_addr = 32'h20;
    @(negedge clk);
    step(); d_req = 1; d_addr = 32'h300;
    step(); if_kill = 1; if_req = 0;
    step(); if_kill = 0;
    @(negedge clk); chk("t5_ir", if_ready, 0);
    @(negedge clk); chk("t5_busy", busy, 0);
    @(negedge clk); chk("t5_en", mem_en, 1); chk("t5_addr", mem_addr, 32'h300);
    step();
    wait_ready(0, 20, n); chk("t5_dlat", n, 2); d_req = 0;

    // kill in the response cycle
    if_req = 1; if_addr = 32'h30;
    @(negedge clk);
    step(); step(); step(); if_kill = 1;
    @(negedge clk); chk("t6_ir", if_ready, 0); chk("t6_busy", busy, 1);
    step(); if_kill = 0; if_req = 0;

    // asynchronous reset in WAIT
    if_req = 1; if_addr = 32'h40;
    @(negedge clk);
    step();
    @(posedge clk); #3;
    chk("t7_busy_pre", busy, 1);
    rst = 1;
    #1;
    chk("t7_busy", busy, 0); chk("t7_en", mem_en, 0);
    if_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t7_noready", {if_ready, d_ready}, 0);
    end
    step();
    if_req = 1; if_addr = 32'h8;
    wait_ready(1, 20, n); chk("t7_ilat", n, 4); if_req = 0;

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
